div_unit: RTL and testbench

- Multi-cycle iterative 32-bit divider serving the execute stage for DIV/DIVU.
- The execute stage issues a request with operands and a signedness flag, then holds the pipeline until ready_output.
- It consumes the 64-bit result as {HI=remainder, LO=quotient} and forwards it to the HI/LO write path.
- Radix-2 restoring algorithm on operand magnitudes, one quotient bit per clock.

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_unit.sv | 157 +++++++++++++++
 tb/tb_div_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared encodings and constants for the iterative divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  typedef logic [63:0] double_reg_bus_t;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, result {remainder, quotient}.
// Optional DIV_EARLY_TERM_EN skips the iterations when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                signed_div_input,
  input  logic [DATA_W-1:0]   dividend_input,
  input  logic [DATA_W-1:0]   divisor_input,
  input  logic                start_input,
  input  logic                annul_input,
  output logic [2*DATA_W-1:0] result_output,
  output logic                ready_output
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? ({DATA_W{1'b0}} - v) : v;
  endfunction

  div_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                signed_q;
  logic                dvd_neg_q;
  logic                dvs_neg_q;
  logic [DATA_W-1:0]   dvs_mag_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  logic                in_dvd_neg_s;
  logic                in_dvs_neg_s;
  logic [DATA_W-1:0]   in_dvd_mag_s;
  logic [DATA_W-1:0]   in_dvs_mag_s;
  logic [DATA_W:0]     partial_s;
  logic [DATA_W:0]     diff_s;
  logic                commit_s;
  logic [DATA_W-1:0]   rem_d;
  logic [DATA_W-1:0]   quo_d;
  logic [DATA_W-1:0]   quo_fix_s;
  logic [DATA_W-1:0]   rem_fix_s;

  // Operand magnitudes at acceptance and one restoring step of the iteration.
  always_comb begin
    in_dvd_neg_s = signed_div_input & dividend_input[DATA_W-1];
    in_dvs_neg_s = signed_div_input & divisor_input[DATA_W-1];
    in_dvd_mag_s = cond_neg(in_dvd_neg_s, dividend_input);
    in_dvs_mag_s = cond_neg(in_dvs_neg_s, divisor_input);
    partial_s    = {rem_q, quo_q[DATA_W-1]};
    diff_s       = partial_s - {1'b0, dvs_mag_q};
    commit_s     = ~diff_s[DATA_W];
    if (commit_s) begin
      rem_d = diff_s[DATA_W-1:0];
    end else begin
      rem_d = partial_s[DATA_W-1:0];
    end
    quo_d     = {quo_q[DATA_W-2:0], commit_s};
    quo_fix_s = cond_neg(signed_q & (dvd_neg_q ^ dvs_neg_q), quo_q);
    rem_fix_s = cond_neg(signed_q & dvd_neg_q, rem_q);
  end

  // Control FSM with registered ready/result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= DIV_FREE;
      cnt_q     <= {CNT_W{1'b0}};
      signed_q  <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      dvs_mag_q <= {DATA_W{1'b0}};
      rem_q     <= {DATA_W{1'b0}};
      quo_q     <= {DATA_W{1'b0}};
      result_q  <= {(2*DATA_W){1'b0}};
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_q)
        DIV_FREE: begin
          ready_q  <= DIV_RESULT_NOT_READY;
          result_q <= {(2*DATA_W){1'b0}};
          if (start_input == DIV_START && !annul_input) begin
            signed_q  <= signed_div_input;
            dvd_neg_q <= in_dvd_neg_s;
            dvs_neg_q <= in_dvs_neg_s;
            dvs_mag_q <= in_dvs_mag_s;
            if (divisor_input == {DATA_W{1'b0}}) begin
              state_q <= DIV_BYZERO;
              cnt_q   <= {CNT_W{1'b0}};
              rem_q   <= {DATA_W{1'b0}};
              quo_q   <= {DATA_W{1'b0}};
`ifdef DIV_EARLY_TERM_EN
            end else if (in_dvd_mag_s < in_dvs_mag_s) begin
              // Land on the sign-fixup step directly: quotient 0, remainder |dividend|.
              state_q <= DIV_ON;
              cnt_q   <= CNT_LAST;
              rem_q   <= in_dvd_mag_s;
              quo_q   <= {DATA_W{1'b0}};
`endif
            end else begin
              state_q <= DIV_ON;
              cnt_q   <= {CNT_W{1'b0}};
              rem_q   <= {DATA_W{1'b0}};
              quo_q   <= in_dvd_mag_s;
            end
          end else begin
            state_q <= DIV_FREE;
          end
        end
        DIV_BYZERO: begin
          ready_q <= DIV_RESULT_NOT_READY;
          if (annul_input) begin
            state_q <= DIV_FREE;
          end else begin
            result_q <= {(2*DATA_W){1'b0}};
            state_q  <= DIV_END;
          end
        end
        DIV_ON: begin
          ready_q <= DIV_RESULT_NOT_READY;
          if (annul_input) begin
            state_q <= DIV_FREE;
          end else if (cnt_q == CNT_LAST) begin
            result_q <= {rem_fix_s, quo_fix_s};
            state_q  <= DIV_END;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DIV_END: begin
          if (start_input == DIV_STOP || annul_input) begin
            state_q  <= DIV_FREE;
            ready_q  <= DIV_RESULT_NOT_READY;
            result_q <= {(2*DATA_W){1'b0}};
          end else begin
            ready_q <= DIV_RESULT_READY;
          end
        end
        default: begin
          state_q  <= DIV_FREE;
          ready_q  <= DIV_RESULT_NOT_READY;
          result_q <= {(2*DATA_W){1'b0}};
        end
      endcase
    end
  end

  assign result_output = result_q;
  assign ready_output  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic model plus a per-cycle output checker.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        signed_div_input;
  logic [31:0] dividend_input;
  logic [31:0] divisor_input;
  logic        start_input;
  logic        annul_input;
  logic [63:0] result_output;
  logic        ready_output;

  int n_checks = 0;
  int n_err    = 0;

  // Model of the current request: busy, edges since acceptance, latency, result.
  bit          m_busy  = 1'b0;
  int          m_edges = 0;
  int          m_lat   = 0;
  logic [63:0] m_res   = 64'd0;
  logic        exp_rdy;

  div_unit dut (
    .clock            (clock),
    .reset            (reset),
    .signed_div_input (signed_div_input),
    .dividend_input   (dividend_input),
    .divisor_input    (divisor_input),
    .start_input      (start_input),
    .annul_input      (annul_input),
    .result_output    (result_output),
    .ready_output     (ready_output)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] model_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int model_lat(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = (s && a[31]) ? -longint'({{32{a[31]}}, a}) : longint'({32'd0, a});
    mb = (s && b[31]) ? -longint'({{32{b[31]}}, b}) : longint'({32'd0, b});
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_TERM_EN
    if (ma < mb) return 2;
`endif
    if (ma < 0 || mb < 0) return 0;
    return 34;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Per-cycle checker, sampled on the falling edge.
  always @(negedge clock) begin
    exp_rdy = m_busy && (m_edges >= m_lat);
    check("ready_cycle", {63'd0, ready_output}, {63'd0, exp_rdy});
    if (exp_rdy) begin
      check("result_cycle", result_output, m_res);
    end else if (!m_busy) begin
      check("result_idle", result_output, 64'd0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (m_busy) m_edges++;
  endtask

  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
    signed_div_input = s;
    dividend_input   = a;
    divisor_input    = b;
    start_input      = 1'b1;
    m_res   = model_div(s, a, b);
    m_lat   = model_lat(s, a, b);
    m_edges = -1;
    m_busy  = 1'b1;
  endtask

  task automatic run_req(input string name, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    issue(s, a, b);
    check({name, "_model"}, m_res, exp);
    step();
    dividend_input = ~a;
    divisor_input  = b ^ 32'h0000_0005;
    signed_div_input = ~s;
    while (m_edges < m_lat + 2) begin
      step();
      if (m_edges == m_lat) begin
        check({name, "_ready"}, {63'd0, ready_output}, 64'd1);
        check({name, "_result"}, result_output, exp);
      end
    end
    start_input = 1'b0;
    step();
    m_busy = 1'b0;
    check({name, "_drop"}, {63'd0, ready_output}, 64'd0);
  endtask

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11] = '{
    '{1'b0, 32'd100,       32'd7,         {32'h0000_0002, 32'h0000_000E}},
    '{1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}},
    '{1'b1, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}},
    '{1'b0, 32'h0000_1234, 32'd0,         64'd0},
    '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}},
    '{1'b0, 32'd5,         32'd9,         {32'h0000_0005, 32'h0000_0000}},
    '{1'b0, 32'hFFFF_FFFF, 32'h10,        {32'h0000_000F, 32'h0FFF_FFFF}},
    '{1'b1, 32'hFFFF_FFFD, 32'd5,         {32'hFFFF_FFFD, 32'h0000_0000}},
    '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}},
    '{1'b0, 32'hFFFF_FFFF, 32'd1,         {32'h0000_0000, 32'hFFFF_FFFF}},
    '{1'b1, 32'h8000_0000, 32'd2,         {32'h0000_0000, 32'hC000_0000}}
  };

  initial begin
    reset = 1'b0;
    signed_div_input = 1'b0;
    dividend_input = 32'd0;
    divisor_input  = 32'd0;
    start_input = 1'b0;
    annul_input = 1'b0;
    step(); step();
    check("reset_ready", {63'd0, ready_output}, 64'd0);
    check("reset_result", result_output, 64'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Annul mid-operation, then immediately re-request 9/3.
    issue(1'b0, 32'd100, 32'd7);
    step();
    while (m_edges < 10) step();
    annul_input = 1'b1;
    dividend_input = 32'd9;
    divisor_input  = 32'd3;
    step();
    m_busy = 1'b0;
    annul_input = 1'b0;
    check("annul_ready", {63'd0, ready_output}, 64'd0);
    run_req("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Asynchronous reset in the middle of the iteration.
    issue(1'b0, 32'd100, 32'd7);
    step();
    for (int k = 0; k < 5; k++) step();
    #2;
    m_busy = 1'b0;
    reset = 1'b0;
    start_input = 1'b0;
    #1;
    check("rst_on_ready", {63'd0, ready_output}, 64'd0);
    check("rst_on_result", result_output, 64'd0);
    step(); step();
    reset = 1'b1;
    run_req("after_rst", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0000_000F, 32'h0FFF_FFFF});

    // Asynchronous reset while a result is being presented.
    issue(1'b0, 32'd100, 32'd7);
    step();
    while (m_edges < m_lat + 1) step();
    #2;
    m_busy = 1'b0;
    reset = 1'b0;
    start_input = 1'b0;
    #1;
    check("rst_end_ready", {63'd0, ready_output}, 64'd0);
    check("rst_end_result", result_output, 64'd0);
    step();
    reset = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
